// File: rtl/vend_pkg.sv
// Shared constants for the two-product vending sequencer: state encoding,
// product select codes and coin unit values (credit is kept in half-yuan units).
// Ports: none (package).
package vend_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_VEND    = 2'd2;
  localparam logic [1:0] S_CHANGE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = S_IDLE,
    ST_COLLECT = S_COLLECT,
    ST_VEND    = S_VEND,
    ST_CHANGE  = S_CHANGE
  } state_e;

  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_COLA  = 2'd1;
  localparam logic [1:0] SEL_WATER = 2'd2;

  localparam logic [1:0] UNIT_ONE  = 2'd2;
  localparam logic [1:0] UNIT_HALF = 2'd1;

  // Credit added by one cycle of coin pulses; both coins together give 3.
  function automatic logic [1:0] coin_units(input logic one, input logic half);
    coin_units = (one ? UNIT_ONE : 2'd0) + (half ? UNIT_HALF : 2'd0);
  endfunction

endpackage

// File: rtl/vend_seq_ctrl_if.sv
// Keypad / coin acceptor / dispenser bundle for vend_seq_ctrl.
// master: drives coins, select, cancel, dispenser ready; observes dispense, change, status.
// slave : the sequencer side (inputs and outputs reversed).
interface vend_seq_ctrl_if #(
  parameter int CREDIT_W = 5
);
  logic                piOne;
  logic                piHalf;
  logic [1:0]          piSel;
  logic                piCancel;
  logic                piDispReady;
  logic                OCola;
  logic                OWater;
  logic                OChgOne;
  logic                OChgHalf;
  logic                OReject;
  logic                OBusy;
  logic [CREDIT_W-1:0] OCredit;

  modport master (
    output piOne, piHalf, piSel, piCancel, piDispReady,
    input  OCola, OWater, OChgOne, OChgHalf, OReject, OBusy, OCredit
  );

  modport slave (
    input  piOne, piHalf, piSel, piCancel, piDispReady,
    output OCola, OWater, OChgOne, OChgHalf, OReject, OBusy, OCredit
  );
endinterface

// File: rtl/vend_change_gen.sv
// Change coin selector: picks the next coin to pay from the remaining credit.
// Latency: combinational; the caller registers the coin strobes.
// Backpressure: pays nothing while ready_i is low.
// Ports: en_i (paying change), ready_i (mechanism free), credit_i (remaining credit),
//        chg_one_o / chg_half_o (coin to pay), dec_o (amount to subtract from credit).
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 5
) (
  input  logic                en_i,
  input  logic                ready_i,
  input  logic [CREDIT_W-1:0] credit_i,
  output logic                chg_one_o,
  output logic                chg_half_o,
  output logic [CREDIT_W-1:0] dec_o
);

  always_comb begin
    chg_one_o  = 1'b0;
    chg_half_o = 1'b0;
    dec_o      = '0;
    if (en_i && ready_i) begin
      // Largest coin first so a refund uses the fewest mechanism cycles.
      if (credit_i >= CREDIT_W'(UNIT_ONE)) begin
        chg_one_o = 1'b1;
        dec_o     = CREDIT_W'(UNIT_ONE);
      end else if (credit_i == CREDIT_W'(UNIT_HALF)) begin
        chg_half_o = 1'b1;
        dec_o      = CREDIT_W'(UNIT_HALF);
      end
    end
  end

endmodule

// File: rtl/vend_seq_ctrl.sv
// Two-product vending sequencer: coin credit accumulation, select arbitration,
// dispense, then change paid one coin per dispenser grant.
// Latency: all outputs registered; select in cycle N with ready high -> product pulse in N+2.
// Backpressure: VEND/CHANGE stall while piDispReady is low; coins arriving then are rejected.
// Ports: sys_clk, sysRstN (async active-low), bus (vend_seq_ctrl_if.slave).
// Build option: VEND_TIMEOUT_EN adds an idle timeout that refunds credit from COLLECT.
module vend_seq_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = 5,
  parameter int PRICE_COLA  = 5,
  parameter int PRICE_WATER = 3,
  parameter int MAX_CREDIT  = 20,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic      sys_clk,
  input  logic      sysRstN,
  vend_seq_ctrl_if.slave bus
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE_COLA);
  localparam logic [CREDIT_W-1:0] PRICE_W = CREDIT_W'(PRICE_WATER);
  localparam logic [CREDIT_W:0]   MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          prod_q, prod_d;
  logic                cola_q, cola_d;
  logic                water_q, water_d;
  logic                chg_one_q, chg_one_d;
  logic                chg_half_q, chg_half_d;
  logic                reject_q, reject_d;

  logic                coin;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic [CREDIT_W-1:0] vend_price;
  logic                chg_en;
  logic                chg_one;
  logic                chg_half;
  logic [CREDIT_W-1:0] chg_dec;

  assign coin       = bus.piOne | bus.piHalf;
  // One extra bit so credit+3 near the ceiling cannot wrap before the compare.
  assign coin_sum   = {1'b0, credit_q} + (CREDIT_W+1)'(coin_units(bus.piOne, bus.piHalf));
  assign coin_fits  = (coin_sum <= MAX_X);
  assign vend_price = (prod_q == SEL_COLA) ? PRICE_C : PRICE_W;
  assign chg_en     = (state_q == ST_CHANGE);

  vend_change_gen #(
    .CREDIT_W (CREDIT_W)
  ) u_change_gen (
    .en_i       (chg_en),
    .ready_i    (bus.piDispReady),
    .credit_i   (credit_q),
    .chg_one_o  (chg_one),
    .chg_half_o (chg_half),
    .dec_o      (chg_dec)
  );

`ifdef VEND_TIMEOUT_EN
  localparam int                TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             evt;
  logic             tmo_hit;

  assign evt     = coin | (bus.piSel != SEL_NONE) | bus.piCancel;
  // Fires on the TIMEOUT_CYC-th consecutive quiet cycle spent in COLLECT.
  assign tmo_hit = (state_q == ST_COLLECT) && !evt && (tmo_q == TMO_LAST);

  always_comb begin
    tmo_d = tmo_q;
    if (evt || tmo_hit) begin
      tmo_d = '0;
    end else if (state_q == ST_COLLECT) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sysRstN) begin
    if (!sysRstN) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end
`else
  // No timeout: credit waits in COLLECT indefinitely. TIMEOUT_CYC stays in the
  // parameter list so both builds share one instantiation.
  if (TIMEOUT_CYC < 0) begin : g_tmo_cfg
  end
`endif

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    prod_d     = prod_q;
    cola_d     = 1'b0;
    water_d    = 1'b0;
    chg_one_d  = 1'b0;
    chg_half_d = 1'b0;
    reject_d   = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        // An over-ceiling add is discarded whole, never clipped.
        if (coin) begin
          if (coin_fits) credit_d = coin_sum[CREDIT_W-1:0];
          else           reject_d = 1'b1;
        end
        // Select is judged against the registered credit; a coin landing in the
        // same cycle is still banked and shows up as change later.
        if ((state_q == ST_COLLECT) && bus.piCancel) begin
          state_d = ST_CHANGE;
        end else if ((bus.piSel == SEL_COLA) && (credit_q >= PRICE_C)) begin
          prod_d  = SEL_COLA;
          state_d = ST_VEND;
        end else if ((bus.piSel == SEL_WATER) && (credit_q >= PRICE_W)) begin
          prod_d  = SEL_WATER;
          state_d = ST_VEND;
        end else if (credit_d != '0) begin
          state_d = ST_COLLECT;
`ifdef VEND_TIMEOUT_EN
          if (tmo_hit) state_d = ST_CHANGE;
`endif
        end
      end

      ST_VEND: begin
        reject_d = coin;
        if (bus.piDispReady) begin
          cola_d   = (prod_q == SEL_COLA);
          water_d  = (prod_q != SEL_COLA);
          // Cannot underflow: the select was only accepted with credit >= price.
          credit_d = credit_q - vend_price;
          state_d  = (credit_q == vend_price) ? ST_IDLE : ST_CHANGE;
        end
      end

      ST_CHANGE: begin
        reject_d   = coin;
        chg_one_d  = chg_one;
        chg_half_d = chg_half;
        credit_d   = credit_q - chg_dec;
        if (credit_d == '0) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sysRstN) begin
    if (!sysRstN) begin
      state_q    <= ST_IDLE;
      credit_q   <= '0;
      prod_q     <= SEL_NONE;
      cola_q     <= 1'b0;
      water_q    <= 1'b0;
      chg_one_q  <= 1'b0;
      chg_half_q <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      prod_q     <= prod_d;
      cola_q     <= cola_d;
      water_q    <= water_d;
      chg_one_q  <= chg_one_d;
      chg_half_q <= chg_half_d;
      reject_q   <= reject_d;
    end
  end

  assign bus.OCola    = cola_q;
  assign bus.OWater   = water_q;
  assign bus.OChgOne  = chg_one_q;
  assign bus.OChgHalf = chg_half_q;
  assign bus.OReject  = reject_q;
  assign bus.OBusy    = (state_q == ST_VEND) || (state_q == ST_CHANGE);
  assign bus.OCredit  = credit_q;

endmodule
